// File: rtl/button_debouncer_array_if.sv
// Bundle between raw button pins and the debounced event outputs of button_debouncer_array.
// The master drives the raw buttons; the slave (the debouncer) drives the debounced outputs.
interface button_debouncer_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] rel;
  logic [CHANNELS-1:0] hold;
  logic                active;

  modport master (output button, input level, press, rel, hold, active);
  modport slave  (input button, output level, press, rel, hold, active);
endinterface

// File: rtl/button_debouncer_array.sv
// Multi-channel button debouncer: 2-flop sync, stable-window accept, press/release pulses.
// Long-press/auto-repeat pulses on bus.hold exist only when DEBOUNCER_HOLD_EN is defined.
module button_debouncer_array #(
  parameter int          CHANNELS     = 4,
  parameter int unsigned MAX_COUNT    = 1000000,
  parameter int          WIDTH        = 20,
  parameter int          ACTIVE_LOW   = 0,
  parameter int unsigned HOLD_COUNT   = 50000000,
  parameter int unsigned REPEAT_COUNT = 10000000,
  parameter int          HOLD_WIDTH   = 26
) (
  input logic                      clk,
  input logic                      rst_n,
  button_debouncer_array_if.slave  bus
);

  localparam logic             INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX_COUNT - 1);

  logic [CHANNELS-1:0] s1, s2, n;
  logic [CHANNELS-1:0] level_q, press_q, rel_q, hold_q;
  logic [CHANNELS-1:0] accept;
  logic [WIDTH-1:0]    cnt [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= {CHANNELS{INACTIVE}};
      s2 <= {CHANNELS{INACTIVE}};
    end else begin
      s1 <= bus.button;
      s2 <= s1;
    end
  end

  // Normalise polarity so everything downstream is pressed-high.
  assign n = s2 ^ {CHANNELS{INACTIVE}};

  always_comb begin
    accept = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      accept[ch] = (n[ch] != level_q[ch]) && (cnt[ch] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      press_q <= '0;
      rel_q   <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (n[ch] == level_q[ch]) begin
          cnt[ch] <= '0;
        end else if (accept[ch]) begin
          level_q[ch] <= n[ch];
          cnt[ch]     <= '0;
          press_q[ch] <= n[ch];
          rel_q[ch]   <= ~n[ch];
        end else begin
          cnt[ch] <= cnt[ch] + WIDTH'(1);
        end
      end
    end
  end

`ifdef DEBOUNCER_HOLD_EN
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HOLD_COUNT - 1);
  localparam logic [HOLD_WIDTH-1:0] REPEAT_LAST =
    HOLD_WIDTH'((REPEAT_COUNT > 0) ? (REPEAT_COUNT - 1) : 0);
  localparam logic                  REPEAT_OFF  = (REPEAT_COUNT == 0);

  logic [HOLD_WIDTH-1:0] hcnt [CHANNELS];
  logic [CHANNELS-1:0]   rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep    <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        hcnt[ch] <= '0;
      end
    end else begin
      hold_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!level_q[ch]) begin
          hcnt[ch] <= '0;
          rep[ch]  <= 1'b0;
        end else if (rep[ch] && REPEAT_OFF) begin
          hcnt[ch] <= hcnt[ch];
        end else if (hcnt[ch] == (rep[ch] ? REPEAT_LAST : HOLD_LAST)) begin
          // A release being accepted on this same edge swallows the pulse.
          hold_q[ch] <= ~accept[ch];
          hcnt[ch]   <= '0;
          rep[ch]    <= 1'b1;
        end else begin
          hcnt[ch] <= hcnt[ch] + HOLD_WIDTH'(1);
        end
      end
    end
  end
`else
  assign hold_q = '0;
`endif

  assign bus.level  = level_q;
  assign bus.press  = press_q;
  assign bus.rel    = rel_q;
  assign bus.hold   = hold_q;
  assign bus.active = |level_q;

endmodule

// File: tb/tb_button_debouncer_array.sv
// Directed bench for button_debouncer_array: one active-high and one active-low instance,
// MAX_COUNT=4, hold timing HOLD_COUNT=10 / REPEAT_COUNT=5 when DEBOUNCER_HOLD_EN is defined.
module tb_button_debouncer_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  logic [3:0] seen;
  logic [3:0] exp_hold;

  always #5 clk = ~clk;

  button_debouncer_array_if #(.CHANNELS(4)) bus_hi ();
  button_debouncer_array_if #(.CHANNELS(4)) bus_lo ();

  button_debouncer_array #(
    .CHANNELS(4), .MAX_COUNT(4), .WIDTH(2), .ACTIVE_LOW(0),
    .HOLD_COUNT(10), .REPEAT_COUNT(5), .HOLD_WIDTH(4)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .bus(bus_hi)
  );

  button_debouncer_array #(
    .CHANNELS(4), .MAX_COUNT(4), .WIDTH(2), .ACTIVE_LOW(1),
    .HOLD_COUNT(10), .REPEAT_COUNT(5), .HOLD_WIDTH(4)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .bus(bus_lo)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    bus_hi.button = 4'b0000;
    bus_lo.button = 4'b1111;

    // Reset state
    tick(2);
    chk("rst_level_hi", {4'b0, bus_hi.level}, 8'h0);
    chk("rst_press_hi", {4'b0, bus_hi.press}, 8'h0);
    chk("rst_rel_hi", {4'b0, bus_hi.rel}, 8'h0);
    chk("rst_hold_hi", {4'b0, bus_hi.hold}, 8'h0);
    chk("rst_active_hi", {7'b0, bus_hi.active}, 8'h0);
    chk("rst_level_lo", {4'b0, bus_lo.level}, 8'h0);
    rst_n = 1'b1;
    tick(6);
    chk("idle_level_hi", {4'b0, bus_hi.level}, 8'h0);
    chk("idle_level_lo", {4'b0, bus_lo.level}, 8'h0);

    // Single press on ch0
    bus_hi.button[0] = 1'b1;
    tick(5);
    chk("ch0_edge5_level", {4'b0, bus_hi.level}, 8'h0);
    chk("ch0_edge5_press", {4'b0, bus_hi.press}, 8'h0);
    tick(1);
    chk("ch0_edge6_level", {4'b0, bus_hi.level}, 8'h1);
    chk("ch0_edge6_press", {4'b0, bus_hi.press}, 8'h1);
    chk("ch0_edge6_active", {7'b0, bus_hi.active}, 8'h1);
    tick(1);
    chk("ch0_edge7_press", {4'b0, bus_hi.press}, 8'h0);
    chk("ch0_edge7_level", {4'b0, bus_hi.level}, 8'h1);

    // Glitch rejection on ch1: 3 high, 1 low, 3 high, then low
    seen = 4'b0;
    bus_hi.button[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen = seen | {1'b0, bus_hi.level[1], bus_hi.press[1], bus_hi.rel[1]};
    end
    bus_hi.button[1] = 1'b0;
    tick(1);
    seen = seen | {1'b0, bus_hi.level[1], bus_hi.press[1], bus_hi.rel[1]};
    bus_hi.button[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen = seen | {1'b0, bus_hi.level[1], bus_hi.press[1], bus_hi.rel[1]};
    end
    bus_hi.button[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | {1'b0, bus_hi.level[1], bus_hi.press[1], bus_hi.rel[1]};
    end
    chk("glitch_ch1_activity", {4'b0, seen}, 8'h0);
    chk("glitch_ch0_kept", {4'b0, bus_hi.level}, 8'h1);

    // Press then release on ch2
    bus_hi.button[2] = 1'b1;
    tick(6);
    chk("ch2_press", {4'b0, bus_hi.press}, 8'h4);
    tick(2);
    bus_hi.button[2] = 1'b0;
    seen = 4'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen = seen | bus_hi.press | bus_hi.rel;
    end
    chk("ch2_edge5_quiet", {4'b0, seen}, 8'h0);
    chk("ch2_edge5_level", {4'b0, bus_hi.level}, 8'h5);
    tick(1);
    chk("ch2_edge6_rel", {4'b0, bus_hi.rel}, 8'h4);
    chk("ch2_edge6_level", {4'b0, bus_hi.level}, 8'h1);
    chk("ch2_edge6_press", {4'b0, bus_hi.press}, 8'h0);
    tick(1);
    chk("ch2_edge7_rel", {4'b0, bus_hi.rel}, 8'h0);

    // Active-low instance, simultaneous events
    bus_lo.button = 4'b0101;
    tick(5);
    chk("lo_edge5_press", {4'b0, bus_lo.press}, 8'h0);
    tick(1);
    chk("lo_edge6_press", {4'b0, bus_lo.press}, 8'ha);
    chk("lo_edge6_level", {4'b0, bus_lo.level}, 8'ha);
    tick(1);
    chk("lo_edge7_press", {4'b0, bus_lo.press}, 8'h0);
    chk("lo_edge7_level", {4'b0, bus_lo.level}, 8'ha);

    // Long press on ch3
    bus_hi.button[3] = 1'b1;
    tick(6);
    chk("ch3_press", {4'b0, bus_hi.press}, 8'h8);
    for (int k = 1; k <= 45; k++) begin
      tick(1);
`ifdef DEBOUNCER_HOLD_EN
      exp_hold = (k == 10 || k == 15 || k == 20 || k == 25 || k == 30 || k == 35) ? 4'h8 : 4'h0;
`else
      exp_hold = 4'h0;
`endif
      chk($sformatf("ch3_hold_k%0d", k), {4'b0, bus_hi.hold & 4'h8}, {4'b0, exp_hold});
      if (k == 32) bus_hi.button[3] = 1'b0;
      if (k == 38) chk("ch3_release", {4'b0, bus_hi.rel}, 8'h8);
    end
`ifndef DEBOUNCER_HOLD_EN
    chk("hold_all_zero", {4'b0, bus_hi.hold}, 8'h0);
`endif

    // Async reset mid-count on ch0 (level=1, cnt=2)
    bus_hi.button[0] = 1'b0;
    tick(4);
    chk("pre_rst_level", {4'b0, bus_hi.level}, 8'h1);
    rst_n = 1'b0;
    #1;
    chk("async_level_hi", {4'b0, bus_hi.level}, 8'h0);
    chk("async_active_hi", {7'b0, bus_hi.active}, 8'h0);
    chk("async_level_lo", {4'b0, bus_lo.level}, 8'h0);
    tick(1);
    rst_n = 1'b1;
    bus_hi.button[0] = 1'b1;
    tick(5);
    chk("post_rst_edge5_hi", {4'b0, bus_hi.press}, 8'h0);
    chk("post_rst_edge5_lo", {4'b0, bus_lo.press}, 8'h0);
    tick(1);
    chk("post_rst_edge6_hi", {4'b0, bus_hi.press}, 8'h1);
    chk("post_rst_edge6_lo", {4'b0, bus_lo.press}, 8'ha);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
